debug_unlock_ctrl: RTL and testbench



---
 rtl/debug_unlock_ctrl.sv | 129 ++++++++++++
 tb/tb_debug_unlock_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/debug_unlock_ctrl.sv
// Challenge/response debug unlock controller: key compare, timed unlock window,
// and brute-force lockout after repeated failures.
module debug_unlock_ctrl #(
   parameter int unsigned KEY_W          = 16,
   parameter int unsigned MAX_ATTEMPTS   = 3,
   parameter int unsigned LOCKOUT_CYCLES = 256,
   parameter int unsigned UNLOCK_CYCLES  = 1024,
   localparam int unsigned FCW           = $clog2(MAX_ATTEMPTS + 1)
) (
   input  logic             Clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [KEY_W-1:0] req_key,
   input  logic [KEY_W-1:0] key_ref,
   input  logic             relock,
   output logic             debug_unlocked,
   output logic             resp_valid,
   output logic             resp_pass,
   output logic             lockout,
   output logic [FCW-1:0]   fail_count
);

   localparam int unsigned TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
   localparam int unsigned TW   = $clog2(TMAX);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CHECK    = 2'd1,
      UNLOCKED = 2'd2,
      LOCKOUT  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [FCW-1:0]   fail_q, fail_d, fail_inc;
   logic             unl_d, rv_d, rp_d, lo_d;
   logic             match;

   assign req_ready  = (state_q == IDLE) & ~reset;
   assign fail_count = fail_q;

   // An all-zero reference means unprovisioned and can never match.
   assign match    = (key_q == key_ref) && (key_ref != '0);
   assign fail_inc = (fail_q == FCW'(MAX_ATTEMPTS)) ? fail_q : fail_q + FCW'(1);

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      timer_d = timer_q;
      fail_d  = fail_q;
      unl_d   = 1'b0;
      rv_d    = 1'b0;
      rp_d    = 1'b0;
      lo_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               key_d   = req_key;
               state_d = CHECK;
            end
         end
         CHECK: begin
            rv_d = 1'b1;
            if (relock) begin
               state_d = IDLE;
            end else if (match) begin
               state_d = UNLOCKED;
               unl_d   = 1'b1;
               rp_d    = 1'b1;
               fail_d  = '0;
               timer_d = TW'(UNLOCK_CYCLES - 1);
            end else begin
               fail_d = fail_inc;
               if (fail_inc == FCW'(MAX_ATTEMPTS)) begin
                  state_d = LOCKOUT;
                  lo_d    = 1'b1;
                  timer_d = TW'(LOCKOUT_CYCLES - 1);
               end else begin
                  state_d = IDLE;
               end
            end
         end
         UNLOCKED: begin
            if (relock || timer_q == '0) begin
               state_d = IDLE;
               timer_d = '0;
            end else begin
               unl_d   = 1'b1;
               timer_d = timer_q - TW'(1);
            end
         end
         LOCKOUT: begin
            if (timer_q == '0) begin
               state_d = IDLE;
               fail_d  = '0;
            end else begin
               lo_d    = 1'b1;
               timer_d = timer_q - TW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         state_q        <= IDLE;
         key_q          <= '0;
         timer_q        <= '0;
         fail_q         <= '0;
         debug_unlocked <= 1'b0;
         resp_valid     <= 1'b0;
         resp_pass      <= 1'b0;
         lockout        <= 1'b0;
      end else begin
         state_q        <= state_d;
         key_q          <= key_d;
         timer_q        <= timer_d;
         fail_q         <= fail_d;
         debug_unlocked <= unl_d;
         resp_valid     <= rv_d;
         resp_pass      <= rp_d;
         lockout        <= lo_d;
      end
   end

endmodule

// File: tb/tb_debug_unlock_ctrl.sv
// Directed bench for debug_unlock_ctrl: vector table for short sequences plus
// hand-written window/lockout/reset sequences.
module tb_debug_unlock_ctrl;

   logic        Clk = 1'b0;
   logic        reset, req_valid, relock;
   logic [15:0] req_key, key_ref;
   logic        req_ready, debug_unlocked, resp_valid, resp_pass, lockout;
   logic [1:0]  fail_count;

   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;

   debug_unlock_ctrl #(
      .KEY_W(16),
      .MAX_ATTEMPTS(3),
      .LOCKOUT_CYCLES(256),
      .UNLOCK_CYCLES(1024)
   ) dut (
      .Clk(Clk),
      .reset(reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_key(req_key),
      .key_ref(key_ref),
      .relock(relock),
      .debug_unlocked(debug_unlocked),
      .resp_valid(resp_valid),
      .resp_pass(resp_pass),
      .lockout(lockout),
      .fail_count(fail_count)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic        rst;
      logic        vld;
      logic [15:0] key;
      logic [15:0] kref;
      logic        rlk;
      logic        rdy;
      logic        unl;
      logic        rv;
      logic        rp;
      logic        lo;
      logic [1:0]  fc;
   } vec_t;

   localparam int NV = 16;
   vec_t tbl [NV];

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic e_rdy, input logic e_unl,
                             input logic e_rv, input logic e_rp, input logic e_lo,
                             input logic [1:0] e_fc);
      chk({tag, ".req_ready"}, 32'(req_ready), 32'(e_rdy));
      chk({tag, ".debug_unlocked"}, 32'(debug_unlocked), 32'(e_unl));
      chk({tag, ".resp_valid"}, 32'(resp_valid), 32'(e_rv));
      if (e_rv) chk({tag, ".resp_pass"}, 32'(resp_pass), 32'(e_rp));
      chk({tag, ".lockout"}, 32'(lockout), 32'(e_lo));
      chk({tag, ".fail_count"}, 32'(fail_count), 32'(e_fc));
   endtask

   // Accept at first edge, response visible after the second edge.
   task automatic submit(input logic [15:0] k);
      req_valid = 1'b1;
      req_key   = k;
      step();
      req_valid = 1'b0;
      step();
   endtask

   initial begin
      int n, guard, rvc, bad;

      //            rst   vld   key       kref      rlk   rdy   unl   rv    rp    lo    fc
      tbl[0]  = '{1'b1, 1'b0, 16'h0000, 16'hA5C3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[1]  = '{1'b0, 1'b0, 16'h0000, 16'hA5C3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[2]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[3]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1};
      tbl[4]  = '{1'b0, 1'b1, 16'h1234, 16'hA5C3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
      tbl[5]  = '{1'b0, 1'b0, 16'h0000, 16'hA5C3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2};
      tbl[6]  = '{1'b0, 1'b1, 16'hA5C3, 16'hA5C3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2};
      tbl[7]  = '{1'b0, 1'b0, 16'h0000, 16'hA5C3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0};
      tbl[8]  = '{1'b0, 1'b0, 16'h0000, 16'hA5C3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[9]  = '{1'b0, 1'b0, 16'h0000, 16'hA5C3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[10] = '{1'b0, 1'b1, 16'hA5C3, 16'hA5C3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[11] = '{1'b0, 1'b0, 16'h0000, 16'hA5C3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
      tbl[12] = '{1'b0, 1'b1, 16'hA5C3, 16'hA5C3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[13] = '{1'b0, 1'b1, 16'h1234, 16'hA5C3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0};
      tbl[14] = '{1'b0, 1'b1, 16'h1234, 16'hA5C3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[15] = '{1'b0, 1'b0, 16'h0000, 16'hA5C3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};

      reset = 1'b1; req_valid = 1'b0; relock = 1'b0; req_key = '0; key_ref = 16'hA5C3;

      for (int i = 0; i < NV; i++) begin
         reset     = tbl[i].rst;
         req_valid = tbl[i].vld;
         req_key   = tbl[i].key;
         key_ref   = tbl[i].kref;
         relock    = tbl[i].rlk;
         step();
         check_outs($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].unl, tbl[i].rv,
                    tbl[i].rp, tbl[i].lo, tbl[i].fc);
      end

      // Full unlock window; a pending request must wait until IDLE.
      reset = 1'b0; relock = 1'b0; key_ref = 16'hA5C3;
      req_valid = 1'b1; req_key = 16'hA5C3;
      step();
      chk("win.accept_ready", 32'(req_ready), 32'd0);
      req_key = 16'h1234;
      step();
      check_outs("win.pass", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
      key_ref = 16'h0000;
      n = 1; guard = 0; rvc = 0;
      while (debug_unlocked === 1'b1 && guard < 2000) begin
         step();
         guard++;
         if (debug_unlocked === 1'b1) n++;
         if (resp_valid === 1'b1) rvc++;
      end
      chk("win.length", 32'(n), 32'd1024);
      chk("win.no_accept", 32'(rvc), 32'd0);
      chk("win.end_ready", 32'(req_ready), 32'd1);
      step();
      chk("win.late_accept", 32'(req_ready), 32'd0);
      req_valid = 1'b0;
      key_ref = 16'hA5C3;
      step();
      check_outs("win.late_resp", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);

      // Three failures -> lockout of exactly 256 cycles; relock ignored.
      reset = 1'b1; step(); reset = 1'b0;
      chk("lk.reset_fc", 32'(fail_count), 32'd0);
      submit(16'h1234);
      check_outs("lk.f1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
      submit(16'h1234);
      check_outs("lk.f2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
      submit(16'h1234);
      check_outs("lk.f3", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3);
      relock = 1'b1;
      n = 1; guard = 0; bad = 0;
      while (lockout === 1'b1 && guard < 600) begin
         step();
         guard++;
         if (lockout === 1'b1) begin
            n++;
            if (req_ready !== 1'b0) bad++;
         end
      end
      relock = 1'b0;
      chk("lk.length", 32'(n), 32'd256);
      chk("lk.ready_low", 32'(bad), 32'd0);
      check_outs("lk.exit", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

      // Relock at cycle 10 of the window, with req_valid held high.
      submit(16'hA5C3);
      check_outs("rl.pass", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
      req_valid = 1'b1; req_key = 16'hA5C3;
      bad = 0;
      for (int i = 0; i < 9; i++) begin
         step();
         if (debug_unlocked !== 1'b1 || resp_valid !== 1'b0) bad++;
      end
      chk("rl.held", 32'(bad), 32'd0);
      relock = 1'b1;
      step();
      relock = 1'b0;
      check_outs("rl.exit", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      step();
      chk("rl.accept", 32'(req_ready), 32'd0);
      req_valid = 1'b0;
      step();
      check_outs("rl.repass", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
      relock = 1'b1; step(); relock = 1'b0;

      // Reset mid-lockout (cycle 100) and mid-window.
      submit(16'h1111);
      submit(16'h2222);
      submit(16'h3333);
      check_outs("rs.lock", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3);
      for (int i = 0; i < 99; i++) step();
      chk("rs.lock_c100", 32'(lockout), 32'd1);
      reset = 1'b1;
      step();
      check_outs("rs.lock_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      reset = 1'b0;
      step();
      check_outs("rs.lock_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      submit(16'hA5C3);
      check_outs("rs.unl", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
      for (int i = 0; i < 5; i++) step();
      reset = 1'b1;
      step();
      check_outs("rs.unl_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      reset = 1'b0;
      submit(16'hA5C3);
      check_outs("rs.relock_pass", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
